// File: rtl/arbitration_packet_mux.sv
// Packet-level steering stage behind a shiftable fixed-priority arbiter.
// It owns the arbiter's request vector and rotates priority after each packet.
// While a packet is in flight it holds the lock on its source, so packets never interleave.
// Accepted beats go into a 2-entry FIFO, so the output keeps full throughput under backpressure.
module arbitration_packet_mux #(
   parameter int N  = 8,
   parameter int W  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    in_valid_i,
   input  logic [N*W-1:0]  in_data_i,
   input  logic [N-1:0]    in_last_i,
   output logic [N-1:0]    in_ready_o,
   output logic [N-1:0]    arb_req_o,
   input  logic [N-1:0]    arb_grant_i,
   output logic            arb_shift_o,
   output logic            out_valid_o,
   output logic [W-1:0]    out_data_o,
   output logic            out_last_o,
   output logic [SW-1:0]   out_src_o,
   input  logic            out_ready_i,
   output logic            err_grant_o
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [N-1:0]          owner_q, owner_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  err_q, err_d;
   logic [1:0][W-1:0]     mem_data_q;
   logic [1:0]            mem_last_q;
   logic [1:0][SW-1:0]    mem_src_q;

   logic                  fifo_ok;
   logic                  pop;
   logic                  accept;
   logic                  grant_onehot;
   logic                  grant_bad;
   logic                  err_cycle;
   logic [N-1:0]          sel_vec;
   logic [W-1:0]          sel_data;
   logic                  sel_last;
   logic [SW-1:0]         sel_idx;

   // Binary index of a one-hot vector; an OR of the set positions is enough when one-hot.
   function automatic logic [SW-1:0] encode_onehot(input logic [N-1:0] vec);
      logic [SW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = idx | SW'(i);
      end
      return idx;
   endfunction

   // Handshake, arbitration interface, source selection and next-state decisions.
   always_comb begin
      fifo_ok      = (count_q < 2'd2) || ((count_q == 2'd2) && out_ready_i);
      pop          = (count_q != 2'd0) && out_ready_i;
      grant_onehot = (arb_grant_i != '0) && ((arb_grant_i & (arb_grant_i - N'(1))) == '0);
      arb_req_o    = '0;
      in_ready_o   = '0;
      accept       = 1'b0;
      grant_bad    = 1'b0;
      err_cycle    = 1'b0;
      sel_vec      = owner_q;
      state_d      = state_q;
      owner_d      = owner_q;

      if (state_q == IDLE) begin
         sel_vec = arb_grant_i;
         if (fifo_ok) arb_req_o = in_valid_i;
         grant_bad = !grant_onehot || ((arb_grant_i & ~arb_req_o) != '0);
         err_cycle = (arb_req_o != '0) && grant_bad;
         if (!err_cycle && (arb_req_o != '0) && fifo_ok) begin
            accept     = 1'b1;
            in_ready_o = arb_grant_i;
         end
      end else begin
         if (fifo_ok) in_ready_o = owner_q;
         accept = fifo_ok && ((owner_q & in_valid_i) != '0);
      end

      if (rst) begin
         arb_req_o  = '0;
         in_ready_o = '0;
         accept     = 1'b0;
         err_cycle  = 1'b0;
      end

      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (sel_vec[i]) sel_data = sel_data | in_data_i[i*W +: W];
      end
      sel_last    = |(sel_vec & in_last_i);
      sel_idx     = encode_onehot(sel_vec);
      arb_shift_o = accept && sel_last;

      if (accept) begin
         if (state_q == IDLE) begin
            owner_d = arb_grant_i;
            if (!sel_last) state_d = LOCKED;
         end else if (sel_last) begin
            state_d = IDLE;
         end
      end

      err_d    = err_q | err_cycle;
      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
      wr_ptr_d = accept ? ~wr_ptr_q : wr_ptr_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Control state: lock owner, FIFO occupancy/pointers and the sticky grant error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         err_q    <= err_d;
      end
   end

   // FIFO storage; a push at full overwrites the slot being popped on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_data_q <= '0;
         mem_last_q <= '0;
         mem_src_q  <= '0;
      end else if (accept) begin
         mem_data_q[wr_ptr_q] <= sel_data;
         mem_last_q[wr_ptr_q] <= sel_last;
         mem_src_q[wr_ptr_q]  <= sel_idx;
      end
   end

   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = out_valid_o ? mem_data_q[rd_ptr_q] : '0;
   assign out_last_o  = out_valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
   assign out_src_o   = out_valid_o ? mem_src_q[rd_ptr_q]  : '0;
   assign err_grant_o = err_q;

endmodule

// File: tb/tb_arbitration_packet_mux.sv
// Bench for arbitration_packet_mux with N=4, W=8. The bench also plays the arbiter:
// a rotating fixed-priority picker whose top priority moves past each packet's source.
module tb_arbitration_packet_mux;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   in_valid_i;
   logic [N*W-1:0] in_data_i;
   logic [N-1:0]   in_last_i;
   logic [N-1:0]   in_ready_o;
   logic [N-1:0]   arb_req_o;
   logic [N-1:0]   arb_grant_i;
   logic           arb_shift_o;
   logic           out_valid_o;
   logic [W-1:0]   out_data_o;
   logic           out_last_o;
   logic [SW-1:0]  out_src_o;
   logic           out_ready_i;
   logic           err_grant_o;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [W-1:0]  data;
      logic          last;
      logic [SW-1:0] src;
   } beat_t;

   typedef struct {
      logic [N-1:0]   v;
      logic [N*W-1:0] d;
      logic [N-1:0]   l;
      logic [N-1:0]   g;
      logic           ordy;
      logic [N-1:0]   xReady;
      logic [N-1:0]   xReq;
      logic           xShift;
      logic           xValid;
      logic [W-1:0]   xData;
      logic [SW-1:0]  xSrc;
      logic           xLast;
   } vec_t;

   vec_t tbl[6];

   beat_t mq[$];
   beat_t seen[$];
   int    mOwner;
   int    mPrio;
   bit    mErr;

   logic [N-1:0] sV;
   logic [N-1:0] sL;
   logic [W-1:0] sD[N];
   logic         sOrdy;
   bit           sForce;
   logic [N-1:0] sFg;
   logic [N-1:0] sG;

   logic [N-1:0] eReq;
   logic [N-1:0] eReady;
   logic         eShift;
   bit           eAcc;
   bit           eErrNow;
   int           eWin;

   arbitration_packet_mux #(.N(N), .W(W), .SW(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .arb_req_o   (arb_req_o),
      .arb_grant_i (arb_grant_i),
      .arb_shift_o (arb_shift_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .out_src_o   (out_src_o),
      .out_ready_i (out_ready_i),
      .err_grant_o (err_grant_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Arbiter model: scan from the current top-priority source upward, wrapping around.
   function automatic logic [N-1:0] arbPick(input logic [N-1:0] req, input int prio);
      logic [N-1:0] g;
      g = '0;
      for (int k = 0; k < N; k++) begin
         int s;
         s = (prio + k) % N;
         if (req[s] && g == '0) g[s] = 1'b1;
      end
      return g;
   endfunction

   task automatic modelClear();
      mq.delete();
      mOwner = -1;
      mPrio  = 0;
      mErr   = 1'b0;
   endtask

   // Expected handshake for this cycle, from the packet-level rules.
   task automatic modelEval();
      int cnt;
      bit ok;
      cnt     = mq.size();
      ok      = (cnt < 2) || (cnt == 2 && sOrdy);
      eAcc    = 1'b0;
      eErrNow = 1'b0;
      eWin    = -1;
      eReq    = '0;
      eReady  = '0;
      eShift  = 1'b0;
      if (mOwner < 0) begin
         eReq = ok ? sV : '0;
         sG   = sForce ? sFg : arbPick(eReq, mPrio);
         if (eReq != '0) eErrNow = ($countones(sG) != 1) || ((sG & ~eReq) != '0);
         if (ok && eReq != '0 && !eErrNow) begin
            for (int k = 0; k < N; k++) if (sG[k]) eWin = k;
            eAcc   = 1'b1;
            eReady = sG;
         end
      end else begin
         sG = sForce ? sFg : '0;
         if (ok) eReady[mOwner] = 1'b1;
         if (ok && sV[mOwner]) begin
            eAcc = 1'b1;
            eWin = mOwner;
         end
      end
      if (eAcc) eShift = sL[eWin];
   endtask

   task automatic modelUpdate();
      beat_t b;
      if (mq.size() != 0 && sOrdy) void'(mq.pop_front());
      if (eAcc) begin
         b.data = sD[eWin];
         b.last = sL[eWin];
         b.src  = SW'(eWin);
         mq.push_back(b);
         if (mOwner < 0 && !sL[eWin]) mOwner = eWin;
         else if (mOwner >= 0 && sL[eWin]) mOwner = -1;
      end
      if (eShift) mPrio = (eWin + 1) % N;
      if (eErrNow) mErr = 1'b1;
   endtask

   task automatic checkOutput();
      check("in_ready", in_ready_o, eReady);
      check("arb_req", arb_req_o, eReq);
      check("arb_shift", arb_shift_o, eShift);
      check("out_valid", out_valid_o, mq.size() != 0);
      check("err_grant", err_grant_o, mErr);
      if (mq.size() != 0) begin
         check("out_data", out_data_o, mq[0].data);
         check("out_last", out_last_o, mq[0].last);
         check("out_src", out_src_o, mq[0].src);
      end
   endtask

   // One model-checked cycle: drive, settle, compare, advance model, cross the edge.
   task automatic applyStimulus();
      beat_t b;
      modelEval();
      in_valid_i  = sV;
      in_last_i   = sL;
      out_ready_i = sOrdy;
      arb_grant_i = sG;
      for (int k = 0; k < N; k++) in_data_i[k*W +: W] = sD[k];
      #1;
      checkOutput();
      if (out_valid_o && sOrdy) begin
         b.data = out_data_o;
         b.last = out_last_o;
         b.src  = out_src_o;
         seen.push_back(b);
      end
      modelUpdate();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      sV = '0; sL = '0; sOrdy = 1'b1; sForce = 1'b0; sFg = '0;
      for (int k = 0; k < N; k++) sD[k] = '0;
      in_valid_i = '0; in_last_i = '0; in_data_i = '0; arb_grant_i = '0; out_ready_i = 1'b1;
   endtask

   task automatic doReset();
      idleInputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelClear();
      seen.delete();
   endtask

   initial begin
      int b;
      tbl[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1] = '{4'b1011, 32'h3300_11F0, 4'b0000, 4'b0010, 1'b1, 4'b0010, 4'b1011, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b1};
      tbl[2] = '{4'b1011, 32'h3300_12F0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 8'h11, 2'd1, 1'b0};
      tbl[3] = '{4'b1011, 32'h3300_13F0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'h12, 2'd1, 1'b0};
      tbl[4] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h13, 2'd1, 1'b1};
      tbl[5] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};

      // Reset state, with busy inputs to show the combinational outputs are held low.
      rst = 1'b1;
      in_valid_i = 4'b1111; in_last_i = 4'b1111; in_data_i = 32'hFFFF_FFFF;
      arb_grant_i = 4'b0001; out_ready_i = 1'b1;
      #12;
      check("rst_in_ready", in_ready_o, 0);
      check("rst_arb_req", arb_req_o, 0);
      check("rst_arb_shift", arb_shift_o, 0);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_out_data", out_data_o, 0);
      check("rst_out_last", out_last_o, 0);
      check("rst_out_src", out_src_o, 0);
      check("rst_err_grant", err_grant_o, 0);
      idleInputs();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single-beat packet from src2, then a locked 3-beat packet from src1.
      for (int i = 0; i < 6; i++) begin
         in_valid_i  = tbl[i].v;
         in_data_i   = tbl[i].d;
         in_last_i   = tbl[i].l;
         arb_grant_i = tbl[i].g;
         out_ready_i = tbl[i].ordy;
         #1;
         check($sformatf("tbl%0d_in_ready", i), in_ready_o, tbl[i].xReady);
         check($sformatf("tbl%0d_arb_req", i), arb_req_o, tbl[i].xReq);
         check($sformatf("tbl%0d_arb_shift", i), arb_shift_o, tbl[i].xShift);
         check($sformatf("tbl%0d_out_valid", i), out_valid_o, tbl[i].xValid);
         check($sformatf("tbl%0d_out_data", i), out_data_o, tbl[i].xData);
         check($sformatf("tbl%0d_out_src", i), out_src_o, tbl[i].xSrc);
         check($sformatf("tbl%0d_out_last", i), out_last_o, tbl[i].xLast);
         @(posedge clk);
         #1;
      end

      // Backpressure: 4-beat packet from src2 with out_ready low for the first 4 cycles.
      doReset();
      b = 0;
      for (int c = 0; c < 10; c++) begin
         sOrdy = (c >= 4);
         sV    = (b < 4) ? 4'b0100 : 4'b0000;
         sL    = (b == 3) ? 4'b0100 : 4'b0000;
         sD[2] = 8'hB0 + 8'(b);
         applyStimulus();
         if (eAcc) b++;
      end
      check("bp_beats_out", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check($sformatf("bp_order%0d", i), seen[i].data, 8'hB0 + 8'(i));

      // Back-to-back single-beat packets from every source.
      doReset();
      sV = 4'b1111; sL = 4'b1111;
      for (int k = 0; k < N; k++) sD[k] = 8'hC0 + 8'(k);
      repeat (5) applyStimulus();
      check("b2b_beats_out", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check($sformatf("b2b_src%0d", i), seen[i].src, i);

      // Illegal two-hot grant in IDLE sets the sticky error and blocks acceptance.
      doReset();
      sV = 4'b0110; sL = 4'b0110; sForce = 1'b1; sFg = 4'b0110;
      applyStimulus();
      sForce = 1'b0; sV = 4'b0001; sL = 4'b0001; sD[0] = 8'h5A;
      repeat (3) applyStimulus();
      check("err_sticky", err_grant_o, 1);

      // Asynchronous reset in the middle of a packet from src3.
      doReset();
      sV = 4'b1000; sL = 4'b0000;
      sD[3] = 8'hD0; applyStimulus();
      sD[3] = 8'hD1; applyStimulus();
      in_valid_i = 4'b1000; in_last_i = 4'b1000; in_data_i = 32'hD200_0000; arb_grant_i = 4'b0000;
      #1;
      check("mid_in_ready", in_ready_o, 4'b1000);
      #1;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid_o, 0);
      check("arst_in_ready", in_ready_o, 0);
      check("arst_arb_req", arb_req_o, 0);
      check("arst_arb_shift", arb_shift_o, 0);
      check("arst_err", err_grant_o, 0);
      idleInputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelClear();
      seen.delete();
      sV = 4'b0010; sL = 4'b0010; sD[1] = 8'hE1;
      applyStimulus();
      sV = 4'b0000; sL = 4'b0000;
      repeat (2) applyStimulus();
      check("post_rst_beats", seen.size(), 1);

      // Random traffic against the model, with occasional forced grants.
      doReset();
      for (int c = 0; c < 400; c++) begin
         sV = N'($urandom);
         for (int k = 0; k < N; k++) begin
            sL[k] = ($urandom_range(0, 2) == 0);
            sD[k] = W'($urandom);
         end
         sOrdy  = ($urandom_range(0, 3) != 0);
         sForce = ($urandom_range(0, 63) == 0);
         sFg    = N'($urandom);
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
